// File: rtl/mem_pkg.sv
// Shared types, opcodes and decode helpers for the MEM-stage load/store engine.
package mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE,
    ST_DRAIN
  } mem_state_e;

  localparam int EXC_ADEL = 13;
  localparam int EXC_ADES = 14;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [7:0] EXE_LB_OP   = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP   = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP   = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP  = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP  = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP   = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP   = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP   = 8'b1110_1011;
  localparam logic [7:0] EXE_ADDU_OP = 8'b0010_0001;

  function automatic logic is_load(input logic [7:0] aluop);
    return aluop inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
  endfunction

  function automatic logic is_store(input logic [7:0] aluop);
    return aluop inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  endfunction

  function automatic logic [1:0] op_size(input logic [7:0] aluop);
    case (aluop)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return SZ_BYTE;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return SZ_HALF;
      default:                          return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a bus read word and sign/zero extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [7:0]  aluop,
  input  logic [1:0]  byte_sel,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // NOTE: every output of a combinational block gets a value on every path, so no latch is inferred.
  always_comb begin
    sel_byte = rdata[{byte_sel, 3'b000} +: 8];
    sel_half = byte_sel[1] ? rdata[31:16] : rdata[15:0];
    case (aluop)
      EXE_LB_OP:  data = {{24{sel_byte[7]}}, sel_byte};
      EXE_LBU_OP: data = {24'h0, sel_byte};
      EXE_LH_OP:  data = {{16{sel_half[15]}}, sel_half};
      EXE_LHU_OP: data = {16'h0, sel_half};
      default:    data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: issues one bus transaction at a time, aligns load
// data, flags AdEL/AdES and stalls upstream while a transaction is in flight.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [7:0]        aluop_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [31:0]       exception_type_i,
  input  logic              flush_i,
  output logic              req_o,
  output logic              wr_o,
  output logic [1:0]        size_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  output logic [3:0]        wstrb_o,
  input  logic              addr_ok_i,
  input  logic              data_ok_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              ok_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [31:0]       exception_type_o,
  output logic [ADDR_W-1:0] bad_vaddr_o
);

  mem_state_e        state;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] load_word;

  logic       load_op;
  logic       store_op;
  logic [1:0] size;
  logic       misaligned;
  logic       fault;
  logic       issue;
  logic [3:0] strb;

  load_align u_load_align (
    .aluop    (aluop_i),
    .byte_sel (addr_i[1:0]),
    .rdata    (rdata_i),
    .data     (load_word)
  );

  always_comb begin
    load_op    = is_load(aluop_i);
    store_op   = is_store(aluop_i);
    size       = op_size(aluop_i);
    misaligned = (size == SZ_HALF && addr_i[0]) ||
                 (size == SZ_WORD && addr_i[1:0] != 2'b00);
    fault      = valid_i && (load_op || store_op) && misaligned;
    // A memory op already carrying an exception must not touch the bus either.
    issue      = valid_i && (load_op || store_op) && !misaligned &&
                 (exception_type_i == 32'h0) && !flush_i;
  end

  // Store lane replication and strobes; inputs are held stable while stalled.
  always_comb begin
    bus_wdata_o = store_data_i;
    strb        = 4'b1111;
    case (size)
      SZ_BYTE: begin
        bus_wdata_o = {4{store_data_i[7:0]}};
        strb        = 4'b0001 << addr_i[1:0];
      end
      SZ_HALF: begin
        bus_wdata_o = {2{store_data_i[15:0]}};
        strb        = addr_i[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    req_o = 1'b0;
    ok_o  = 1'b1;
    case (state)
      ST_IDLE: begin
        req_o = issue;
        ok_o  = !issue;
      end
      ST_REQ: begin
        req_o = !flush_i;
        ok_o  = 1'b0;
      end
      ST_WAIT, ST_DRAIN: ok_o = 1'b0;
      default: ;
    endcase
    if (rst_i) begin
      req_o = 1'b0;
      ok_o  = 1'b1;
    end
  end

  always_comb begin
    exception_type_o = exception_type_i;
    if (fault) begin
      if (load_op) exception_type_o[EXC_ADEL] = 1'b1;
      else         exception_type_o[EXC_ADES] = 1'b1;
    end
    wdata_o     = (state == ST_DONE) ? result : wdata_i;
    bad_vaddr_o = fault ? addr_i : '0;
    if (rst_i) begin
      exception_type_o = 32'h0;
      wdata_o          = '0;
      bad_vaddr_o      = '0;
    end
  end

  assign wr_o       = req_o && store_op;
  assign wstrb_o    = (req_o && store_op) ? strb : 4'b0000;
  assign size_o     = size;
  assign bus_addr_o = addr_i;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= ST_IDLE;
      result <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (issue) state <= addr_ok_i ? ST_WAIT : ST_REQ;
        end
        ST_REQ: begin
          if (flush_i)        state <= ST_IDLE;
          else if (addr_ok_i) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (data_ok_i) begin
            if (flush_i) begin
              state <= ST_IDLE;
            end else begin
              result <= load_op ? load_word : '0;
              state  <= ST_DONE;
            end
          end else if (flush_i) begin
            state <= ST_DRAIN;
          end
        end
        ST_DONE:  state <= ST_IDLE;
        ST_DRAIN: if (data_ok_i) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [7:0]  aluop_i;
  logic [31:0] addr_i;
  logic [31:0] store_data_i;
  logic [31:0] wdata_i;
  logic [31:0] exception_type_i;
  logic        flush_i;
  logic        req_o;
  logic        wr_o;
  logic [1:0]  size_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  wstrb_o;
  logic        addr_ok_i;
  logic        data_ok_i;
  logic [31:0] rdata_i;
  logic        ok_o;
  logic [31:0] wdata_o;
  logic [31:0] exception_type_o;
  logic [31:0] bad_vaddr_o;

  int checks = 0;
  int errors = 0;

  mem_access_unit dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .valid_i          (valid_i),
    .aluop_i          (aluop_i),
    .addr_i           (addr_i),
    .store_data_i     (store_data_i),
    .wdata_i          (wdata_i),
    .exception_type_i (exception_type_i),
    .flush_i          (flush_i),
    .req_o            (req_o),
    .wr_o             (wr_o),
    .size_o           (size_o),
    .bus_addr_o       (bus_addr_o),
    .bus_wdata_o      (bus_wdata_o),
    .wstrb_o          (wstrb_o),
    .addr_ok_i        (addr_ok_i),
    .data_ok_i        (data_ok_i),
    .rdata_i          (rdata_i),
    .ok_o             (ok_o),
    .wdata_o          (wdata_o),
    .exception_type_o (exception_type_o),
    .bad_vaddr_o      (bad_vaddr_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs(input logic [31:0] wd);
    valid_i          = 1'b0;
    aluop_i          = EXE_ADDU_OP;
    addr_i           = 32'h0;
    store_data_i     = 32'h0;
    wdata_i          = wd;
    exception_type_i = 32'h0;
    flush_i          = 1'b0;
    addr_ok_i        = 1'b0;
    data_ok_i        = 1'b0;
    rdata_i          = 32'h0;
  endtask

  // Immediate accept, data_ok next cycle, then one DONE cycle.
  task automatic run_mem(input string tag, input logic [7:0] op, input logic [31:0] addr,
                         input logic [31:0] sd, input logic [31:0] rd, input logic [31:0] exp_w);
    valid_i      = 1'b1;
    aluop_i      = op;
    addr_i       = addr;
    store_data_i = sd;
    addr_ok_i    = 1'b1;
    #1 check({tag, "_req"}, {31'h0, req_o}, 32'h1);
    cyc();
    addr_ok_i = 1'b0;
    data_ok_i = 1'b1;
    rdata_i   = rd;
    #1 check({tag, "_wait_ok"}, {31'h0, ok_o}, 32'h0);
    cyc();
    data_ok_i = 1'b0;
    #1 check({tag, "_done_ok"}, {31'h0, ok_o}, 32'h1);
    check({tag, "_wdata"}, wdata_o, exp_w);
    cyc();
    idle_inputs(32'h0);
  endtask

  initial begin
    idle_inputs(32'h0);
    rst_i    = 1'b1;
    valid_i  = 1'b1;
    aluop_i  = EXE_LW_OP;
    addr_i   = 32'h0000_1000;
    wdata_i  = 32'h7;
    #2;
    check("rst_req", {31'h0, req_o}, 32'h0);
    check("rst_wr", {31'h0, wr_o}, 32'h0);
    check("rst_wstrb", {28'h0, wstrb_o}, 32'h0);
    check("rst_ok", {31'h0, ok_o}, 32'h1);
    check("rst_wdata", wdata_o, 32'h0);
    check("rst_exc", exception_type_o, 32'h0);
    check("rst_bad", bad_vaddr_o, 32'h0);
    idle_inputs(32'h0);
    cyc();
    cyc();
    rst_i = 1'b0;
    cyc();

    // LW with accept delayed two cycles
    valid_i = 1'b1;
    aluop_i = EXE_LW_OP;
    addr_i  = 32'h0000_1000;
    #1 check("lw_c0_req", {31'h0, req_o}, 32'h1);
    check("lw_c0_ok", {31'h0, ok_o}, 32'h0);
    check("lw_size", {30'h0, size_o}, 32'h2);
    check("lw_addr", bus_addr_o, 32'h0000_1000);
    check("lw_wstrb", {28'h0, wstrb_o}, 32'h0);
    check("lw_wr", {31'h0, wr_o}, 32'h0);
    cyc();
    check("lw_c1_req", {31'h0, req_o}, 32'h1);
    check("lw_c1_ok", {31'h0, ok_o}, 32'h0);
    cyc();
    addr_ok_i = 1'b1;
    #1 check("lw_c2_req", {31'h0, req_o}, 32'h1);
    cyc();
    addr_ok_i = 1'b0;
    data_ok_i = 1'b1;
    rdata_i   = 32'hDEAD_BEEF;
    #1 check("lw_c3_req", {31'h0, req_o}, 32'h0);
    check("lw_c3_ok", {31'h0, ok_o}, 32'h0);
    cyc();
    data_ok_i = 1'b0;
    #1 check("lw_done_ok", {31'h0, ok_o}, 32'h1);
    check("lw_done_wdata", wdata_o, 32'hDEAD_BEEF);
    check("lw_done_req", {31'h0, req_o}, 32'h0);
    cyc();
    idle_inputs(32'h0);
    #1 check("lw_after_wdata", wdata_o, 32'h0);
    check("lw_after_ok", {31'h0, ok_o}, 32'h1);
    cyc();

    // Load extension
    run_mem("lb", EXE_LB_OP, 32'h0000_2003, 32'h0, 32'h8012_3456, 32'hFFFF_FF80);
    run_mem("lbu", EXE_LBU_OP, 32'h0000_2003, 32'h0, 32'h8012_3456, 32'h0000_0080);
    run_mem("lh", EXE_LH_OP, 32'h0000_2002, 32'h0, 32'h8012_3456, 32'hFFFF_8012);
    run_mem("lhu", EXE_LHU_OP, 32'h0000_2002, 32'h0, 32'h8012_3456, 32'h0000_8012);
    run_mem("lb0", EXE_LB_OP, 32'h0000_2000, 32'h0, 32'h8012_3456, 32'h0000_0056);

    // Stores: lanes and strobes
    valid_i = 1'b1; aluop_i = EXE_SB_OP; addr_i = 32'h0000_3002; store_data_i = 32'h0000_00AB;
    #1 check("sb_wdata", bus_wdata_o, 32'hABAB_ABAB);
    check("sb_wstrb", {28'h0, wstrb_o}, 32'h4);
    check("sb_wr", {31'h0, wr_o}, 32'h1);
    check("sb_size", {30'h0, size_o}, 32'h0);
    run_mem("sb", EXE_SB_OP, 32'h0000_3002, 32'h0000_00AB, 32'hFFFF_FFFF, 32'h0);
    valid_i = 1'b1; aluop_i = EXE_SH_OP; addr_i = 32'h0000_3002; store_data_i = 32'h1234_BEEF;
    #1 check("sh_wdata", bus_wdata_o, 32'hBEEF_BEEF);
    check("sh_wstrb", {28'h0, wstrb_o}, 32'hC);
    run_mem("sh", EXE_SH_OP, 32'h0000_3002, 32'h1234_BEEF, 32'h0, 32'h0);
    valid_i = 1'b1; aluop_i = EXE_SW_OP; addr_i = 32'h0000_3004; store_data_i = 32'h1234_5678;
    #1 check("sw_wdata", bus_wdata_o, 32'h1234_5678);
    check("sw_wstrb", {28'h0, wstrb_o}, 32'hF);
    run_mem("sw", EXE_SW_OP, 32'h0000_3004, 32'h1234_5678, 32'h0, 32'h0);

    // Misaligned store / load and pre-excepted op: no request
    valid_i = 1'b1; aluop_i = EXE_SH_OP; addr_i = 32'h0000_1001; wdata_i = 32'h33;
    #1 check("ades_req", {31'h0, req_o}, 32'h0);
    check("ades_exc", exception_type_o, 32'h0000_4000);
    check("ades_bad", bad_vaddr_o, 32'h0000_1001);
    check("ades_ok", {31'h0, ok_o}, 32'h1);
    check("ades_wdata", wdata_o, 32'h33);
    cyc();
    check("ades_c1_req", {31'h0, req_o}, 32'h0);
    aluop_i = EXE_LW_OP; addr_i = 32'h0000_1002; exception_type_i = 32'h0000_0001;
    #1 check("adel_exc", exception_type_o, 32'h0000_2001);
    check("adel_bad", bad_vaddr_o, 32'h0000_1002);
    check("adel_req", {31'h0, req_o}, 32'h0);
    addr_i = 32'h0000_1004; exception_type_i = 32'h0000_0100;
    #1 check("preexc_req", {31'h0, req_o}, 32'h0);
    check("preexc_ok", {31'h0, ok_o}, 32'h1);
    check("preexc_exc", exception_type_o, 32'h0000_0100);
    check("preexc_bad", bad_vaddr_o, 32'h0);
    cyc();
    idle_inputs(32'h0);

    // Stray data_ok in IDLE is ignored
    data_ok_i = 1'b1;
    cyc();
    data_ok_i = 1'b0;
    #1 check("stray_ok", {31'h0, ok_o}, 32'h1);
    cyc();

    // Flush while waiting: drain the response, no DONE cycle
    valid_i = 1'b1; aluop_i = EXE_LW_OP; addr_i = 32'h0000_4000; addr_ok_i = 1'b1;
    cyc();
    addr_ok_i = 1'b0;
    flush_i   = 1'b1;
    #1 check("fl_wait_ok", {31'h0, ok_o}, 32'h0);
    cyc();
    idle_inputs(32'h9);
    #1 check("fl_drain1_ok", {31'h0, ok_o}, 32'h0);
    check("fl_drain1_req", {31'h0, req_o}, 32'h0);
    cyc();
    check("fl_drain2_ok", {31'h0, ok_o}, 32'h0);
    cyc();
    data_ok_i = 1'b1;
    rdata_i   = 32'h1111_1111;
    #1 check("fl_drain3_ok", {31'h0, ok_o}, 32'h0);
    cyc();
    data_ok_i = 1'b0;
    #1 check("fl_idle_ok", {31'h0, ok_o}, 32'h1);
    check("fl_idle_wdata", wdata_o, 32'h9);
    run_mem("fl_next", EXE_LW_OP, 32'h0000_0008, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // Asynchronous reset in the middle of WAIT
    valid_i = 1'b1; aluop_i = EXE_LW_OP; addr_i = 32'h0000_5000; addr_ok_i = 1'b1; wdata_i = 32'h44;
    cyc();
    addr_ok_i = 1'b0;
    #1 check("arst_wait_ok", {31'h0, ok_o}, 32'h0);
    #1 rst_i = 1'b1;
    #1 check("arst_ok", {31'h0, ok_o}, 32'h1);
    check("arst_req", {31'h0, req_o}, 32'h0);
    check("arst_wdata", wdata_o, 32'h0);
    cyc();
    rst_i = 1'b0;
    idle_inputs(32'h0);
    cyc();
    valid_i = 1'b1; aluop_i = EXE_ADDU_OP; wdata_i = 32'h5;
    #1 check("addu_wdata", wdata_o, 32'h5);
    check("addu_ok", {31'h0, ok_o}, 32'h1);
    check("addu_req", {31'h0, req_o}, 32'h0);
    cyc();
    idle_inputs(32'h0);
    run_mem("post_rst", EXE_LW_OP, 32'h0000_000C, 32'h0, 32'h0BAD_F00D, 32'h0BAD_F00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
